// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive/transmit paths.
package ps2_pkg;
  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;
  localparam int         PS2_ENTRY_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_rx_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // A PS/2 frame is valid when data plus parity hold an odd number of ones.
  function automatic logic parity_is_odd(input logic [8:0] bits);
    return ^bits;
  endfunction
endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_rd = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/ps2_rx_fifo_controller.sv
// PS/2 receiver: glitch filter, frame checking, watchdog, E0/F0 decoding and
// an event FIFO popped by the keyboard SFR interface.
module ps2_rx_fifo_controller
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter bit STRIP_PREFIX   = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_clk_ps2,
  input  logic                          i_data_ps2,
  input  logic                          i_rx_en_ps2,
  input  logic                          i_rd_en,
  input  logic                          i_clr_err,
  output logic [7:0]                    o_byte_code,
  output logic                          o_break,
  output logic                          o_extended,
  output logic                          o_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow,
  output logic                          o_frame_err,
  output logic                          o_idle
);
  localparam int FCW = $clog2(FILTER_LEN);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_s1, clk_s2, data_s1, data_s2;
  logic filt_clk, filt_prev, filt_flip, fall;
  logic [FCW-1:0] filt_cnt;
  ps2_rx_state_t state, state_nxt;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic par_err;
  logic [WDW-1:0] wd_cnt;
  logic timeout;
  logic shift_en, par_load, bad_start, byte_done, frame_bad, err_set;
  logic ext_pend, brk_pend, push, ovf_set;
  ps2_event_t push_entry, head;
  logic [PS2_ENTRY_W-1:0] head_raw;
  logic fifo_full, fifo_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {clk_s1, clk_s2, data_s1, data_s2} <= 4'b1111;
    end else begin
      clk_s1  <= i_clk_ps2;
      clk_s2  <= clk_s1;
      data_s1 <= i_data_ps2;
      data_s2 <= data_s1;
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  assign filt_flip = (clk_s2 != filt_clk) && (filt_cnt == FCW'(FILTER_LEN - 1));
  assign fall      = filt_prev && !filt_clk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_flip) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!i_rx_en_ps2 || timeout) begin
      state_nxt = ST_IDLE;
    end else if (fall) begin
      unique case (state)
        ST_IDLE:   if (!data_s2) state_nxt = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        ST_PARITY: state_nxt = ST_STOP;
        ST_STOP:   state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en  = 1'b0;
    par_load  = 1'b0;
    bad_start = 1'b0;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    if (i_rx_en_ps2 && fall) begin
      unique case (state)
        ST_IDLE:   bad_start = data_s2;
        ST_DATA:   shift_en  = 1'b1;
        ST_PARITY: par_load  = 1'b1;
        ST_STOP: begin
          byte_done = data_s2 && !par_err;
          frame_bad = !(data_s2 && !par_err);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_err   <= 1'b0;
    end else begin
      if (state == ST_IDLE) bit_cnt <= '0;
      else if (shift_en)    bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shift_reg <= {data_s2, shift_reg[7:1]};
      if (par_load) par_err   <= !parity_is_odd({shift_reg, data_s2});
    end
  end

  // Watchdog restarts on every filtered falling edge while a frame is open.
  assign timeout = i_rx_en_ps2 && (state != ST_IDLE) && !fall &&
                   (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                        wd_cnt <= '0;
    else if (state == ST_IDLE || fall)   wd_cnt <= '0;
    else                                 wd_cnt <= wd_cnt + 1'b1;
  end

  assign err_set = bad_start || frame_bad || timeout;

  always_comb begin
    push            = 1'b0;
    push_entry.ext  = ext_pend;
    push_entry.brk  = brk_pend;
    push_entry.code = shift_reg;
    if (byte_done) begin
      if (!STRIP_PREFIX) begin
        push           = 1'b1;
        push_entry.ext = 1'b0;
        push_entry.brk = 1'b0;
      end else if (shift_reg != PS2_EXT_CODE && shift_reg != PS2_BRK_CODE) begin
        push = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (err_set) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_done && STRIP_PREFIX) begin
      if (shift_reg == PS2_EXT_CODE)      ext_pend <= 1'b1;
      else if (shift_reg == PS2_BRK_CODE) brk_pend <= 1'b1;
      else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  ps2_sync_fifo #(
    .WIDTH (PS2_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (i_rd_en),
    .rd_data (head_raw),
    .count   (o_fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A full FIFO only loses the entry when nothing is popped in the same cycle.
  assign ovf_set = push && fifo_full && !i_rd_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      if (ovf_set)        o_overflow  <= 1'b1;
      else if (i_clr_err) o_overflow  <= 1'b0;
      if (err_set)        o_frame_err <= 1'b1;
      else if (i_clr_err) o_frame_err <= 1'b0;
    end
  end

  assign head        = ps2_event_t'(head_raw);
  assign o_byte_code = head.code;
  assign o_break     = head.brk;
  assign o_extended  = head.ext;
  assign o_valid     = !fifo_empty;
  assign o_idle      = (state == ST_IDLE);
endmodule

// File: tb/tb_ps2_rx_fifo_controller.sv
// Self-checking bench: two receivers (prefix stripping on/off) share the PS/2
// stimulus and are compared against a queue-based event model.
module tb_ps2_rx_fifo_controller;
  localparam int FL = 4;
  localparam int FD = 4;
  localparam int TO = 200;
  localparam int H  = 15;
  localparam int CW = $clog2(FD) + 1;

  logic clk = 1'b0;
  logic rst_n, clk_ps2, data_ps2, rx_en, rd_en, clr_err;
  logic [7:0] code_a, code_b;
  logic brk_a, brk_b, ext_a, ext_b, valid_a, valid_b;
  logic [CW-1:0] count_a, count_b;
  logic ovf_a, ovf_b, err_a, err_b, idle_a, idle_b;
  logic [16:0] vec_a, vec_b;

  int  n_tests, n_fail;
  bit  check_en;
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  bit ext_p[2], brk_p[2], ovf_m[2], err_m[2];

  always #5 clk = ~clk;

  ps2_rx_fifo_controller #(
    .FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO), .STRIP_PREFIX(1'b1)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_ps2(clk_ps2), .i_data_ps2(data_ps2),
    .i_rx_en_ps2(rx_en), .i_rd_en(rd_en), .i_clr_err(clr_err),
    .o_byte_code(code_a), .o_break(brk_a), .o_extended(ext_a), .o_valid(valid_a),
    .o_fifo_count(count_a), .o_overflow(ovf_a), .o_frame_err(err_a), .o_idle(idle_a)
  );

  ps2_rx_fifo_controller #(
    .FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO), .STRIP_PREFIX(1'b0)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_ps2(clk_ps2), .i_data_ps2(data_ps2),
    .i_rx_en_ps2(rx_en), .i_rd_en(rd_en), .i_clr_err(clr_err),
    .o_byte_code(code_b), .o_break(brk_b), .o_extended(ext_b), .o_valid(valid_b),
    .o_fifo_count(count_b), .o_overflow(ovf_b), .o_frame_err(err_b), .o_idle(idle_b)
  );

  assign vec_a = {valid_a, count_a, code_a, brk_a, ext_a, ovf_a, err_a, idle_a};
  assign vec_b = {valid_b, count_b, code_b, brk_b, ext_b, ovf_b, err_b, idle_b};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int msize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void model_pop(int k);
    if (k == 0) begin
      if (q0.size() > 0) void'(q0.pop_front());
    end else begin
      if (q1.size() > 0) void'(q1.pop_front());
    end
  endfunction

  function automatic void model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      ext_p[k] = 0; brk_p[k] = 0; ovf_m[k] = 0; err_m[k] = 0;
    end
  endfunction

  // Instance 0 strips prefixes, instance 1 stores raw bytes.
  function automatic void model_frame(int k, logic [7:0] b, bit good, bit pop_same, bit clr_same);
    logic [9:0] e;
    if (clr_same) begin err_m[k] = 0; ovf_m[k] = 0; end
    if (pop_same) model_pop(k);
    if (!good) begin
      err_m[k] = 1; ext_p[k] = 0; brk_p[k] = 0;
    end else if (k == 0 && b == 8'hE0) begin
      ext_p[0] = 1;
    end else if (k == 0 && b == 8'hF0) begin
      brk_p[0] = 1;
    end else begin
      e = (k == 0) ? {ext_p[0], brk_p[0], b} : {2'b00, b};
      ext_p[k] = 0; brk_p[k] = 0;
      if (msize(k) >= FD) ovf_m[k] = 1;
      else if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endfunction

  function automatic logic [16:0] exp_vec(int k);
    logic [9:0] h;
    int sz;
    sz = msize(k);
    h = 10'h000;
    if (sz != 0) h = (k == 0) ? q0[0] : q1[0];
    return {sz != 0, 3'(sz), h[7:0], h[8], h[9], ovf_m[k], err_m[k], 1'b1};
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("outputs_a", {15'd0, vec_a}, {15'd0, exp_vec(0)});
      checkOutput("outputs_b", {15'd0, vec_b}, {15'd0, exp_vec(1)});
    end
  end

  function automatic logic [10:0] make_frame(logic [7:0] b, bit par_ok, bit stop_ok);
    logic p;
    p = ~^b;
    if (!par_ok) p = ~p;
    return {stop_ok, p, b, 1'b0};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // strobe: 0 none, 1 pop, 2 clear errors -- asserted in the stop-bit detection cycle.
  task automatic applyStimulus(input logic [10:0] fr, input int nbits, input int strobe);
    for (int i = 0; i < nbits; i++) begin
      data_ps2 = fr[i];
      wait_cycles(H);
      clk_ps2 = 1'b0;
      if (i == 10 && strobe != 0) begin
        wait_cycles(2 + FL);
        if (strobe == 1) rd_en = 1'b1;
        else             clr_err = 1'b1;
        wait_cycles(1);
        rd_en = 1'b0;
        clr_err = 1'b0;
        wait_cycles(H - 3 - FL);
      end else begin
        wait_cycles(H);
      end
      clk_ps2 = 1'b1;
    end
    wait_cycles(H);
    data_ps2 = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit par_ok, input bit stop_ok, input int strobe);
    check_en = 0;
    applyStimulus(make_frame(b, par_ok, stop_ok), 11, strobe);
    for (int k = 0; k < 2; k++) model_frame(k, b, par_ok && stop_ok, strobe == 1, strobe == 2);
    check_en = 1;
    wait_cycles(3);
  endtask

  task automatic pop_entry();
    check_en = 0;
    rd_en = 1'b1;
    wait_cycles(1);
    rd_en = 1'b0;
    model_pop(0);
    model_pop(1);
    check_en = 1;
    wait_cycles(2);
  endtask

  task automatic clear_errors();
    check_en = 0;
    clr_err = 1'b1;
    wait_cycles(1);
    clr_err = 1'b0;
    for (int k = 0; k < 2; k++) begin err_m[k] = 0; ovf_m[k] = 0; end
    check_en = 1;
    wait_cycles(2);
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    n_tests = 0; n_fail = 0; check_en = 0;
    rst_n = 1'b0; clk_ps2 = 1'b1; data_ps2 = 1'b1; rx_en = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    model_reset();
    #2;
    checkOutput("reset vector a", {15'd0, vec_a}, 32'h0000_0001);
    checkOutput("reset vector b", {15'd0, vec_b}, 32'h0000_0001);
    wait_cycles(3);
    rst_n = 1'b1;
    check_en = 1;
    wait_cycles(5);

    // Make then break of the same key.
    send_byte(8'h1C, 1, 1, 0);
    send_byte(8'hF0, 1, 1, 0);
    send_byte(8'h1C, 1, 1, 0);
    checkOutput("make count_a", count_a, 2);
    checkOutput("make head_a", {ext_a, brk_a, code_a}, 10'h01C);
    checkOutput("raw count_b", count_b, 3);
    pop_entry();
    checkOutput("break head_a", {ext_a, brk_a, code_a}, 10'h11C);
    pop_entry();
    pop_entry();

    // Extended release.
    send_byte(8'hE0, 1, 1, 0);
    send_byte(8'hF0, 1, 1, 0);
    send_byte(8'h75, 1, 1, 0);
    checkOutput("ext head_a", {ext_a, brk_a, code_a}, 10'h375);
    checkOutput("ext count_a", count_a, 1);
    checkOutput("ext head_b", {ext_b, brk_b, code_b}, 10'h0E0);
    repeat (3) pop_entry();

    // Parity error, clear, then a good frame.
    send_byte(8'h1C, 0, 1, 0);
    checkOutput("parity err_a", err_a, 1);
    checkOutput("parity count_a", count_a, 0);
    clear_errors();
    checkOutput("cleared err_a", err_a, 0);
    send_byte(8'h32, 1, 1, 0);
    checkOutput("after err head_a", {ext_a, brk_a, code_a}, 10'h032);
    pop_entry();

    // A bad start bit drops a pending E0.
    send_byte(8'hE0, 1, 1, 0);
    check_en = 0;
    applyStimulus(11'h001, 1, 0);
    for (int k = 0; k < 2; k++) begin err_m[k] = 1; ext_p[k] = 0; brk_p[k] = 0; end
    check_en = 1;
    wait_cycles(3);
    send_byte(8'h1C, 1, 1, 0);
    checkOutput("badstart head_a", {ext_a, brk_a, code_a}, 10'h01C);
    clear_errors();
    pop_entry();
    pop_entry();

    // Watchdog timeout after four data bits.
    check_en = 0;
    applyStimulus(make_frame(8'h5A, 1, 1), 5, 0);
    wait_cycles(TO - 45);
    checkOutput("pre-timeout err_a", err_a, 0);
    checkOutput("pre-timeout idle_a", idle_a, 0);
    wait_cycles(40);
    checkOutput("timeout err_a", err_a, 1);
    checkOutput("timeout idle_a", idle_a, 1);
    for (int k = 0; k < 2; k++) begin err_m[k] = 1; ext_p[k] = 0; brk_p[k] = 0; end
    check_en = 1;
    wait_cycles(3);
    send_byte(8'h29, 1, 1, 0);
    checkOutput("post-timeout head_a", {ext_a, brk_a, code_a}, 10'h029);
    clear_errors();
    pop_entry();

    // Disabling reception mid-frame discards silently.
    check_en = 0;
    applyStimulus(make_frame(8'h3C, 1, 1), 4, 0);
    rx_en = 1'b0;
    wait_cycles(2);
    checkOutput("disable idle_a", idle_a, 1);
    checkOutput("disable err_a", err_a, 0);
    rx_en = 1'b1;
    check_en = 1;
    wait_cycles(3);
    send_byte(8'h4D, 1, 1, 0);
    pop_entry();

    // Short clock glitches with data low must not start a frame.
    data_ps2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      clk_ps2 = 1'b0;
      wait_cycles($urandom_range(1, FL - 1));
      clk_ps2 = 1'b1;
      wait_cycles(4);
    end
    data_ps2 = 1'b1;
    wait_cycles(H);
    send_byte(8'h6B, 1, 1, 0);
    checkOutput("glitch head_a", {ext_a, brk_a, code_a}, 10'h06B);
    pop_entry();

    // Full FIFO, simultaneous pop/push, overflow, clear racing a new error.
    send_byte(8'h11, 1, 1, 0);
    send_byte(8'h22, 1, 1, 0);
    send_byte(8'h33, 1, 1, 0);
    send_byte(8'h44, 1, 1, 0);
    checkOutput("full count_a", count_a, 4);
    send_byte(8'h55, 1, 1, 1);
    checkOutput("pop+push count_a", count_a, 4);
    checkOutput("pop+push head_a", {ext_a, brk_a, code_a}, 10'h022);
    checkOutput("pop+push ovf_a", ovf_a, 0);
    send_byte(8'h66, 1, 1, 0);
    checkOutput("overflow ovf_a", ovf_a, 1);
    checkOutput("overflow ovf_b", ovf_b, 1);
    pop_entry();
    checkOutput("drain head_a", {ext_a, brk_a, code_a}, 10'h033);
    repeat (3) pop_entry();
    send_byte(8'h1C, 0, 1, 2);
    checkOutput("clr race err_a", err_a, 1);
    checkOutput("clr race ovf_a", ovf_a, 0);
    clear_errors();

    // Randomised traffic with prefixes, errors, pops and clears.
    for (int n = 0; n < 40; n++) begin
      int r, s;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
      s = $urandom_range(0, 7);
      send_byte(b, $urandom_range(0, 7) != 0, $urandom_range(0, 9) != 0,
                (s == 0) ? 1 : (s == 1) ? 2 : 0);
      if ($urandom_range(0, 2) == 0) pop_entry();
      if ($urandom_range(0, 5) == 0) clear_errors();
    end

    // Asynchronous reset in the middle of a frame.
    send_byte(8'h12, 1, 1, 0);
    send_byte(8'h34, 0, 1, 0);
    check_en = 0;
    applyStimulus(make_frame(8'h77, 1, 1), 6, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midframe reset a", {15'd0, vec_a}, 32'h0000_0001);
    checkOutput("midframe reset b", {15'd0, vec_b}, 32'h0000_0001);
    clk_ps2 = 1'b1;
    data_ps2 = 1'b1;
    wait_cycles(2);
    rst_n = 1'b1;
    model_reset();
    check_en = 1;
    wait_cycles(3);
    send_byte(8'h29, 1, 1, 0);
    checkOutput("post-reset head_a", {ext_a, brk_a, code_a}, 10'h029);

    check_en = 0;
    wait_cycles(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
